nano_mem_responder: RTL
=======================

// Module: nano_mem_responder
// PURPOSE
//  - Memory-side responder for the NanoCPU bus: serves address/dataW/ce/we, returns dataR.
//  - 256x16 program/data RAM, plus two memory-mapped registers at the top of the map.
//  - Sequential program loader: fills the RAM from word 0 and holds the CPU in reset until loading finishes.
// PARAMETERS
//  - LOAD_WORDS  256    max words per load session; auto-exit to RUN after word LOAD_WORDS-1
//  - PROT_LIMIT  8'h40  WRITE_PROTECT_EN only: CPU writes to addr < PROT_LIMIT are rejected
// PORTS
//  - ck         in   1   clock, rising edge
//  - rst        in   1   asynchronous, active-low reset
//  - address    in   8   CPU word address
//  - dataW      in   16  CPU write data
//  - ce         in   1   CPU access enable
//  - we         in   1   CPU write enable (qualified by ce)
//  - dataR      out  16  read data, combinational from address
//  - ld_valid   in   1   loader word valid
//  - ld_data    in   16  loader word
//  - ld_last    in   1   marks final loader word (sampled with ld_valid)
//  - ld_ready   out  1   1 = in LOAD state, accepting loader words
//  - load_req   in   1   RUN only: restart a load session
//  - cpu_hold   out  1   active-high reset for the CPU; 1 while in LOAD
//  - out_port   out  16  MMIO output register
//  - prot_err   out  1   sticky protection violation (WRITE_PROTECT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state=LOAD, ptr=0, ld_ready=1, cpu_hold=1, out_port=0, cyc_cnt=0, prot_err=0. RAM contents not cleared.
//  - FSM states: LOAD, RUN.
//  - LOAD: on ld_valid at an edge, mem[ptr]<=ld_data, ptr<=ptr+1.
//    - Go to RUN when ld_valid && (ld_last || ptr==LOAD_WORDS-1). Final word is written at the same edge.
//    - CPU ce/we are ignored. load_req is ignored.
//  - RUN: ld_ready=0, cpu_hold=0. ld_valid is ignored.
//    - load_req=1 at an edge -> LOAD, ptr=0, cyc_cnt=0. out_port keeps its value.
//    - cpu_hold=1 from the cycle after that edge.
//  - CPU write (RUN, ce=1, we=1), committed at the edge:
//    - addr 8'hFF: out_port<=dataW.
//    - addr 8'hFE: ignored (read-only counter).
//    - other addrs: mem[address]<=dataW.
//  - CPU read, zero latency:
//    - dataR = ce ? (addr FF: out_port | addr FE: cyc_cnt | else mem[address]) : 16'h0000.
//    - Needed because the CPU latches dataR at the end of the same cycle it drives address.
//    - Read and write to the same address in one cycle: dataR shows the old value; the new value is visible next cycle.
//  - cyc_cnt: 16-bit, +1 every cycle in RUN, wraps FFFF->0000, cleared when entering LOAD.
//  - ptr: 8-bit. With LOAD_WORDS=256 it never wraps; the auto-exit takes priority.
//  - RAM words FE/FF are shadowed by MMIO on the CPU side but remain writable by the loader.
// CONFIGURATION
//  - `WRITE_PROTECT_EN defined:
//    - RUN-state CPU writes with address < PROT_LIMIT are dropped and set prot_err=1.
//    - prot_err clears only on reset or on entry to LOAD.
//    - Loader writes are never protected.
//  - Not defined: no protection, prot_err tied 0, PROT_LIMIT unused.
// TESTING
//  - Reset, load 0x0010,0x1020,0xF000 (ld_last on 3rd) -> ld_ready=0, cpu_hold=0 next cycle; ce=1, addr=1 -> dataR=0x1020.
//  - RUN write addr 0x80, dataW=0xBEEF -> next cycle read 0x80 = 0xBEEF; ce=0 -> dataR=0x0000.
//  - Write 0xFF=0x00A5 -> out_port=0x00A5, read 0xFF=0x00A5. Write 0xFE=0x1234 -> counter unaffected.
//  - 10 cycles in RUN -> read 0xFE=0x000A. Force 0xFFFF run -> wraps to 0x0000.
//  - load_req mid-RUN -> cpu_hold=1, cyc_cnt=0, next word lands at addr 0. ld_valid during RUN -> RAM unchanged.
//  - WRITE_PROTECT_EN: write 0x10=0xAAAA -> mem[0x10] unchanged, prot_err=1; write 0x40 succeeds; prot_err stays 1 until LOAD.

Source files
------------

// File: rtl/nano_mem_responder.sv
// Memory-side responder for the NanoCPU bus: 256x16 RAM, MMIO out_port/cycle counter, and a
// sequential program loader. Optional CPU write protection is enabled by `WRITE_PROTECT_EN.
module nano_mem_responder #(
  parameter int unsigned LOAD_WORDS = 256,
  parameter logic [7:0]  PROT_LIMIT = 8'h40
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [7:0]  address,
  input  logic [15:0] dataW,
  input  logic        ce,
  input  logic        we,
  output logic [15:0] dataR,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        load_req,
  output logic        cpu_hold,
  output logic [15:0] out_port,
  output logic        prot_err
);

  localparam logic [7:0] LastPtr = 8'(LOAD_WORDS - 1);
  localparam logic [7:0] AddrOut = 8'hFF;
  localparam logic [7:0] AddrCnt = 8'hFE;

  typedef enum logic {StLoad, StRun} state_e;

  state_e      state_q;
  logic [7:0]  ptr_q;
  logic [15:0] out_port_q;
  logic [15:0] cyc_cnt_q;
  logic [15:0] mem [256];

  logic        cpu_wr;
  logic        prot_hit;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  assign cpu_wr = (state_q == StRun) && ce && we;

`ifdef WRITE_PROTECT_EN
  logic prot_err_q;

  assign prot_hit = cpu_wr && (address < PROT_LIMIT);

  // Sticky until the next load session starts.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      prot_err_q <= 1'b0;
    end else if (state_q == StRun) begin
      if (load_req) begin
        prot_err_q <= 1'b0;
      end else if (prot_hit) begin
        prot_err_q <= 1'b1;
      end
    end
  end

  assign prot_err = prot_err_q;
`else
  logic unused_prot_limit;

  assign prot_hit          = 1'b0;
  assign prot_err          = 1'b0;
  assign unused_prot_limit = ^PROT_LIMIT;
`endif

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q    <= StLoad;
      ptr_q      <= '0;
      out_port_q <= '0;
      cyc_cnt_q  <= '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (ld_valid) begin
            ptr_q <= ptr_q + 8'd1;
            if (ld_last || (ptr_q == LastPtr)) begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (load_req) begin
            state_q   <= StLoad;
            ptr_q     <= '0;
            cyc_cnt_q <= '0;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 16'd1;
          end
          if (cpu_wr && !prot_hit && (address == AddrOut)) begin
            out_port_q <= dataW;
          end
        end
      endcase
    end
  end

  // Loader owns the RAM port in LOAD; the CPU owns it in RUN (MMIO addresses excluded).
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = ld_data;
    if (state_q == StLoad) begin
      mem_we = ld_valid;
    end else if (cpu_wr && !prot_hit && (address != AddrOut) && (address != AddrCnt)) begin
      mem_we    = 1'b1;
      mem_addr  = address;
      mem_wdata = dataW;
    end
  end

  always_ff @(posedge ck) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Zero-latency read: the CPU latches dataR in the same cycle it drives address.
  always_comb begin
    dataR = 16'h0000;
    if (ce) begin
      case (address)
        AddrOut: dataR = out_port_q;
        AddrCnt: dataR = cyc_cnt_q;
        default: dataR = mem[address];
      endcase
    end
  end

  assign ld_ready = (state_q == StLoad);
  assign cpu_hold = (state_q == StLoad);
  assign out_port = out_port_q;

endmodule
